// File: rtl/mac_pkg.sv
// Shared definitions for the saturating MAC and its operand feeder.
// Constants describe the MAC datapath; the enum is the feeder's control state.
package mac_pkg;

    localparam int MAC_WIDTH = 14;
    localparam int MAC_ACC_W = 28;
    localparam int MAC_LAT   = 7;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } feed_state_t;

endpackage

// File: rtl/mac_vector_feeder.sv
// Feeds VEC_LEN operand pairs into the MAC, counts its outputs, and returns the dot product.
// Latency: last accept -> res_valid = 1 + MAC_LAT + 1 cycles; CLR_WAIT cycles of clear between vectors.
// Backpressure: s_ready only in STREAM; res_valid holds with stable data until res_ready.
module mac_vector_feeder
    import mac_pkg::*;
#(
    parameter int VEC_LEN   = 8,
    parameter int WIDTH     = MAC_WIDTH,
    parameter int ACC_W     = MAC_ACC_W,
    parameter int CLR_WAIT  = 8,
    parameter int DRAIN_MAX = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_a,
    input  logic signed [WIDTH-1:0] s_b,
    output logic signed [WIDTH-1:0] mac_a,
    output logic signed [WIDTH-1:0] mac_b,
    output logic                    mac_valid_in,
    output logic                    mac_reset,
    input  logic signed [ACC_W-1:0] mac_f,
    input  logic                    mac_valid_out,
    output logic signed [ACC_W-1:0] res_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    err_timeout,
    output logic                    err_spurious
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam int DRN_W = $clog2(DRAIN_MAX + 1);
    localparam int CLR_W = $clog2(CLR_WAIT + 1);

    localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] VEC_FULL = CNT_W'(VEC_LEN);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_MAX - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_WAIT - 1);

    feed_state_t      state;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [CLR_W-1:0] clr_cnt;

    logic accept;
    logic count_en;
    logic last_done;

    assign accept    = s_valid && s_ready;
    // MAC results overlap issue, so completions are counted in STREAM as well as DRAIN.
    assign count_en  = mac_valid_out && (state == ST_STREAM || state == ST_DRAIN);
    assign last_done = count_en && (done_cnt == VEC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_CLEAR;
            issue_cnt    <= '0;
            done_cnt     <= '0;
            drain_cnt    <= '0;
            clr_cnt      <= '0;
            s_ready      <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            mac_reset    <= 1'b1;
            res_data     <= '0;
            res_valid    <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            mac_valid_in <= 1'b0;

            if (mac_valid_out && (state == ST_CLEAR || state == ST_RESULT)) begin
                err_spurious <= 1'b1;
            end

            if (count_en && done_cnt != VEC_FULL) begin
                done_cnt <= done_cnt + 1'b1;
            end

            case (state)
                ST_CLEAR: begin
                    mac_reset <= 1'b0;
                    if (clr_cnt == CLR_LAST) begin
                        clr_cnt <= '0;
                        s_ready <= 1'b1;
                        state   <= ST_STREAM;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                ST_STREAM: begin
                    // Operand register only loads on accept, so s_valid gaps stall it.
                    if (accept) begin
                        mac_a        <= s_a;
                        mac_b        <= s_b;
                        mac_valid_in <= 1'b1;
                        if (issue_cnt == VEC_LAST) begin
                            issue_cnt <= '0;
                            drain_cnt <= '0;
                            s_ready   <= 1'b0;
                            state     <= ST_DRAIN;
                        end else begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (last_done) begin
                        res_data  <= mac_f;
                        res_valid <= 1'b1;
                        state     <= ST_RESULT;
                    end else if (drain_cnt == DRN_LAST) begin
                        err_timeout <= 1'b1;
                        mac_reset   <= 1'b1;
                        clr_cnt     <= '0;
                        done_cnt    <= '0;
                        issue_cnt   <= '0;
                        drain_cnt   <= '0;
                        state       <= ST_CLEAR;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        mac_reset <= 1'b1;
                        clr_cnt   <= '0;
                        done_cnt  <= '0;
                        issue_cnt <= '0;
                        drain_cnt <= '0;
                        state     <= ST_CLEAR;
                    end
                end

                default: begin
                    mac_reset <= 1'b1;
                    clr_cnt   <= '0;
                    s_ready   <= 1'b0;
                    res_valid <= 1'b0;
                    state     <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Bench for mac_vector_feeder paired with a cycle-accurate saturating MAC model.
// Expected dot products come from a step-wise saturating sum over the operand lists.
module tb_mac_vector_feeder;
    import mac_pkg::*;

    localparam int VL   = 4;
    localparam int W    = MAC_WIDTH;
    localparam int AW   = MAC_ACC_W;
    localparam int CLRW = 8;
    localparam int DMAX = 32;

    logic                 clk;
    logic                 reset;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [W-1:0]  s_a;
    logic signed [W-1:0]  s_b;
    logic signed [W-1:0]  mac_a;
    logic signed [W-1:0]  mac_b;
    logic                 mac_valid_in;
    logic                 mac_reset;
    logic signed [AW-1:0] mac_f;
    logic                 mac_valid_out;
    logic signed [AW-1:0] res_data;
    logic                 res_valid;
    logic                 res_ready;
    logic                 err_timeout;
    logic                 err_spurious;

    logic suppress;
    logic inject;

    int vectors;
    int miscompares;

    typedef struct {
        logic [VL-1:0][W-1:0] a;
        logic [VL-1:0][W-1:0] b;
        int                   gap;
        int                   hold;
        longint               exp;
    } vec_t;

    vec_t tbl [5];

    mac_vector_feeder #(
        .VEC_LEN  (VL),
        .WIDTH    (W),
        .ACC_W    (AW),
        .CLR_WAIT (CLRW),
        .DRAIN_MAX(DMAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_valid_in (mac_valid_in),
        .mac_reset    (mac_reset),
        .mac_f        (mac_f),
        .mac_valid_out(mac_valid_out),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [AW-1:0] sat(input longint x);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) <<< (AW - 1)) - 1;
        lo = -(longint'(1) <<< (AW - 1));
        r  = (x > hi) ? hi : ((x < lo) ? lo : x);
        return r[AW-1:0];
    endfunction

    // MAC model: product pipeline of MAC_LAT stages, accumulator visible with valid_out.
    logic                 v_pipe [MAC_LAT];
    longint               p_pipe [MAC_LAT];
    logic signed [AW-1:0] acc;

    always @(posedge clk) begin
        if (mac_reset) begin
            for (int i = 0; i < MAC_LAT; i++) v_pipe[i] <= 1'b0;
            acc <= '0;
        end else begin
            v_pipe[0] <= mac_valid_in;
            p_pipe[0] <= longint'(mac_a) * longint'(mac_b);
            for (int i = 1; i < MAC_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                p_pipe[i] <= p_pipe[i-1];
            end
            if (v_pipe[MAC_LAT-2]) acc <= sat(longint'(acc) + p_pipe[MAC_LAT-2]);
        end
    end

    assign mac_valid_out = (v_pipe[MAC_LAT-1] && !suppress) || inject;
    assign mac_f         = acc;

    function automatic longint ref_dot(input logic [VL-1:0][W-1:0] a, input logic [VL-1:0][W-1:0] b);
        longint s;
        s = 0;
        for (int k = 0; k < VL; k++) s = sat(s + longint'($signed(a[k])) * longint'($signed(b[k])));
        return s;
    endfunction

    function automatic logic [VL-1:0][W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        logic [VL-1:0][W-1:0] r;
        r[0] = e0[W-1:0];
        r[1] = e1[W-1:0];
        r[2] = e2[W-1:0];
        r[3] = e3[W-1:0];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t        v;
        logic [31:0] rv;
        for (int k = 0; k < VL; k++) begin
            rv = $urandom;
            v.a[k] = rv[20] ? 14'h2000 : rv[W-1:0];
            v.b[k] = rv[21] ? 14'h2000 : rv[W+15:16];
        end
        v.gap  = $urandom_range(0, 2);
        v.hold = $urandom_range(0, 3);
        v.exp  = ref_dot(v.a, v.b);
        return v;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        check({p, "_s_ready"},      s_ready, 0);
        check({p, "_mac_reset"},    mac_reset, 1);
        check({p, "_mac_valid_in"}, mac_valid_in, 0);
        check({p, "_mac_a"},        mac_a, 0);
        check({p, "_mac_b"},        mac_b, 0);
        check({p, "_res_valid"},    res_valid, 0);
        check({p, "_res_data"},     res_data, 0);
        check({p, "_err_timeout"},  err_timeout, 0);
        check({p, "_err_spurious"}, err_spurious, 0);
    endtask

    // Offers the first stop_at pairs; returns at the negedge of the cycle after the last accept.
    task automatic issue_vec(input vec_t v, input int stop_at,
                             output int vin_hi, output int vin_rise, output bit ok);
        int          n;
        int          gap_left;
        int          guard;
        logic        prev;
        logic [31:0] rv;
        n = 0; gap_left = 0; guard = 0; prev = 1'b0;
        vin_hi = 0; vin_rise = 0;
        while (n < stop_at && guard < 200) begin
            if (gap_left > 0) begin
                s_valid = 1'b0;
                rv      = $urandom;
                s_a     = rv[W-1:0];
                s_b     = rv[W+15:16];
                gap_left--;
            end else begin
                s_valid = 1'b1;
                s_a     = v.a[n];
                s_b     = v.b[n];
                if (s_ready) begin
                    n++;
                    gap_left = v.gap;
                end
            end
            @(negedge clk);
            guard++;
            if (mac_valid_in) begin
                vin_hi++;
                if (!prev) vin_rise++;
            end
            prev = mac_valid_in;
        end
        s_valid = 1'b0;
        ok = (n == stop_at);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int vh;
        int vr;
        int lat;
        bit ok;
        res_ready = (v.hold == 0);
        issue_vec(v, VL, vh, vr, ok);
        check({nm, "_accepted"}, ok, 1);
        if (!ok) return;
        lat = 1;
        while (!res_valid && lat < 60) begin
            @(negedge clk);
            lat++;
            if (mac_valid_in) vh++;
        end
        check({nm, "_latency"}, lat, 9);
        check({nm, "_result"}, res_data, v.exp);
        check({nm, "_vin_pulses"}, vh, VL);
        if (v.gap > 0) check({nm, "_vin_rises"}, vr, VL);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check({nm, "_hold_valid"}, res_valid, 1);
            check({nm, "_hold_data"}, res_data, v.exp);
            check({nm, "_hold_sready"}, s_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check({nm, "_released"}, res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t ones;
        int   vh;
        int   vr;
        int   lat;
        int   hi;
        int   first;
        bit   ok;
        bit   saw;

        vectors = 0; miscompares = 0;
        reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0;
        res_ready = 1'b1; suppress = 1'b0; inject = 1'b0;

        tbl[0] = '{a: pk(1, 2, 3, 4), b: pk(5, 6, 7, 8), gap: 0, hold: 0, exp: 70};
        tbl[1] = '{a: pk(1, 2, 3, 4), b: pk(5, 6, 7, 8), gap: 1, hold: 0, exp: 70};
        tbl[2] = '{a: pk(-8192, -8192, -8192, -8192), b: pk(-8192, -8192, -8192, -8192),
                   gap: 0, hold: 0, exp: 134217727};
        tbl[3] = '{a: pk(-1, 0, 0, 0), b: pk(1, 0, 0, 0), gap: 0, hold: 0, exp: -1};
        tbl[4] = '{a: pk(3, -4, 5, -6), b: pk(7, 8, -9, 10), gap: 0, hold: 10, exp: -116};
        ones   = '{a: pk(1, 1, 1, 1), b: pk(1, 1, 1, 1), gap: 0, hold: 0, exp: 4};

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");

        reset = 1'b1;
        hi = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mac_reset) hi++;
            if (s_ready) begin
                first = i;
                break;
            end
            @(negedge clk);
        end
        check("clr_pulse_cycles", hi, 1);
        check("s_ready_rise_cycle", first, 8);
        @(negedge clk);

        for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("tbl%0d", t));

        for (int r = 0; r < 6; r++) begin
            v = rand_vec();
            run_vec(v, $sformatf("rnd%0d", r));
        end

        check("to_pre", err_timeout, 0);
        suppress = 1'b1;
        issue_vec(tbl[0], VL, vh, vr, ok);
        check("to_accepted", ok, 1);
        lat = 1; saw = 1'b0;
        while (!err_timeout && lat < 80) begin
            @(negedge clk);
            lat++;
            if (res_valid) saw = 1'b1;
        end
        check("to_latency", lat, 33);
        check("to_no_result", saw, 0);
        check("to_clear_pulse", mac_reset, 1);
        suppress = 1'b0;
        v = rand_vec();
        run_vec(v, "after_to");
        check("to_sticky", err_timeout, 1);

        check("sp_pre", err_spurious, 0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        check("sp_flag", err_spurious, 1);

        issue_vec(tbl[0], 2, vh, vr, ok);
        check("mid_accepted", ok, 1);
        reset = 1'b0;
        #1;
        chk_reset("mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_vec(ones, "mid_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
